// File: rtl/ntt_mod_mult_barrett_if.sv
// ntt_mod_mult_barrett_if: operand/result handshake bundle for ntt_mod_mult_barrett
//   slave  : multiplier view (in_a/in_b/in_side/in_vld/out_rdy in; in_rdy/out_z/out_side/out_err/out_vld out)
//   master : source/sink view, directions mirrored
interface ntt_mod_mult_barrett_if #(
  parameter int MOD_W  = 64,
  parameter int SIDE_W = 8
);
  logic [MOD_W-1:0]  in_a;
  logic [MOD_W-1:0]  in_b;
  logic [SIDE_W-1:0] in_side;
  logic              in_vld;
  logic              in_rdy;
  logic [MOD_W-1:0]  out_z;
  logic [SIDE_W-1:0] out_side;
  logic              out_err;
  logic              out_vld;
  logic              out_rdy;
  modport slave (
    input  in_a, in_b, in_side, in_vld, out_rdy,
    output in_rdy, out_z, out_side, out_err, out_vld
  );
  modport master (
    output in_a, in_b, in_side, in_vld, out_rdy,
    input  in_rdy, out_z, out_side, out_err, out_vld
  );
endinterface

// File: rtl/ntt_mod_mult_barrett.sv
// ntt_mod_mult_barrett: pipelined (a*b) mod MOD_M via Barrett reduction, 5 stages + output register
//   clk, a_rst_n (async active-low), bus (slave modport: operands+tag in, result+tag+err out, valid/ready both sides)
//   Optional macro NTT_MOD_MULT_RANGE_CHECK_EN: flags operands >= MOD_M on out_err; otherwise out_err = 0
module ntt_mod_mult_barrett #(
  parameter int               MOD_W  = 64,
  parameter logic [MOD_W-1:0] MOD_M  = 64'hFFFFFFFF00000001,
  parameter int               SIDE_W = 8
) (
  input logic                   clk,
  input logic                   a_rst_n,
  ntt_mod_mult_barrett_if.slave bus
);
  localparam int XW = 2 * MOD_W;
  localparam int RW = MOD_W + 2;
  localparam int PW = 2 * MOD_W + 2;
  localparam logic [XW:0]    MU_FULL = {1'b1, {XW{1'b0}}} / {{(MOD_W + 1){1'b0}}, MOD_M};
  localparam logic [MOD_W:0] MU      = MU_FULL[MOD_W:0];
  localparam logic [RW-1:0]  M1      = RW'(MOD_M);
  localparam logic [RW-1:0]  M2      = RW'(MOD_M) << 1;
  logic                          en, acc;
  logic [4:0]                    v_q, v_d;
  logic [4:0][SIDE_W-1:0]        side_q, side_d;
  logic [MOD_W-1:0]              a_q, a_d, b_q, b_d;
  logic [XW-1:0]                 x_q, x_d;
  logic [MOD_W:0]                q_q, q_d;
  logic [RW-1:0]                 xl_q, xl_d;
  logic [RW-1:0]                 r_q, r_d;
  logic [RW-1:0]                 rr_q, rr_d;
  logic                          ge1_q, ge1_d, ge2_q, ge2_d;
  logic                          out_vld_q, out_vld_d;
  logic [MOD_W-1:0]              out_z_q, out_z_d;
  logic [SIDE_W-1:0]             out_side_q, out_side_d;
  logic [PW-1:0]                 qp;
  logic [RW-1:0]                 r_sel;
  logic                          unused_bits;
  // Every stage, valid bits included, advances only when the output slot is free or draining.
  always_comb begin
    en         = ~out_vld_q | bus.out_rdy;
    acc        = en & bus.in_vld;
    v_d        = en ? {v_q[3:0], bus.in_vld} : v_q;
    side_d     = en ? {side_q[3:0], acc ? bus.in_side : side_q[0]} : side_q;
    a_d        = acc ? bus.in_a : a_q;
    b_d        = acc ? bus.in_b : b_q;
    x_d        = en ? XW'(a_q) * XW'(b_q) : x_q;
    // q estimate: (x >> (k-1)) * MU >> (k+1); undershoots floor(x/M) by at most 2.
    qp         = PW'(x_q[XW-1:MOD_W-1]) * PW'(MU);
    q_d        = en ? qp[PW-1:MOD_W+1] : q_q;
    xl_d       = en ? x_q[RW-1:0] : xl_q;
    // x - q*M < 3M < 2^(k+2), so the low k+2 bits of each term are enough.
    r_d        = en ? xl_q - RW'(q_q) * M1 : r_q;
    rr_d       = en ? r_q : rr_q;
    ge1_d      = en ? r_q >= M1 : ge1_q;
    ge2_d      = en ? r_q >= M2 : ge2_q;
    r_sel      = ge2_q ? rr_q - M2 : ge1_q ? rr_q - M1 : rr_q;
    out_vld_d  = en ? v_q[4] : out_vld_q;
    out_z_d    = en ? r_sel[MOD_W-1:0] : out_z_q;
    out_side_d = en ? side_q[4] : out_side_q;
  end
  assign unused_bits = ^{qp[MOD_W:0], r_sel[RW-1:MOD_W]};
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      v_q        <= '0;
      side_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      q_q        <= '0;
      xl_q       <= '0;
      r_q        <= '0;
      rr_q       <= '0;
      ge1_q      <= 1'b0;
      ge2_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_z_q    <= '0;
      out_side_q <= '0;
    end else begin
      v_q        <= v_d;
      side_q     <= side_d;
      a_q        <= a_d;
      b_q        <= b_d;
      x_q        <= x_d;
      q_q        <= q_d;
      xl_q       <= xl_d;
      r_q        <= r_d;
      rr_q       <= rr_d;
      ge1_q      <= ge1_d;
      ge2_q      <= ge2_d;
      out_vld_q  <= out_vld_d;
      out_z_q    <= out_z_d;
      out_side_q <= out_side_d;
    end
  end
`ifdef NTT_MOD_MULT_RANGE_CHECK_EN
  logic [4:0] err_q, err_d;
  logic       out_err_q, out_err_d;
  always_comb begin
    err_d     = en ? {err_q[3:0], acc ? (bus.in_a >= MOD_M) | (bus.in_b >= MOD_M) : err_q[0]} : err_q;
    out_err_d = en ? err_q[4] : out_err_q;
  end
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      err_q     <= '0;
      out_err_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      out_err_q <= out_err_d;
    end
  end
  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif
  assign bus.in_rdy   = en;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_z    = out_z_q;
  assign bus.out_side = out_side_q;
endmodule

// File: tb/tb_ntt_mod_mult_barrett.sv
// tb_ntt_mod_mult_barrett: directed + random-handshake checks of ntt_mod_mult_barrett (Goldilocks modulus)
module tb_ntt_mod_mult_barrett;
  localparam int          MOD_W  = 64;
  localparam int          SIDE_W = 8;
  localparam logic [63:0] M      = 64'hFFFFFFFF00000001;
`ifdef NTT_MOD_MULT_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  typedef struct packed {logic [63:0] z; logic [7:0] side; logic err;} exp_t;
  typedef struct packed {logic [63:0] a; logic [63:0] b; logic [63:0] z; logic e;} vec_t;
  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  logic rnd = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t me;
  logic stall_p = 1'b0;
  logic [63:0] pz;
  logic [7:0]  ps;
  logic        pe;
  ntt_mod_mult_barrett_if #(.MOD_W(MOD_W), .SIDE_W(SIDE_W)) bus ();
  ntt_mod_mult_barrett #(.MOD_W(MOD_W), .MOD_M(M), .SIDE_W(SIDE_W)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [7:0] s);
    exp_t        e;
    logic [127:0] p;
    p      = (128'(a) * 128'(b)) % 128'(M);
    e.z    = p[63:0];
    e.side = s;
    e.err  = RC & ((a >= M) | (b >= M));
    return e;
  endfunction
  // Scoreboard and hold checker; samples mid-cycle, between the drive point and the next edge.
  always @(negedge clk) begin
    if (!a_rst_n) stall_p = 1'b0;
    else begin
      if (stall_p) begin
        chk("hold_vld", 128'(bus.out_vld), 128'(1));
        chk("hold_z", 128'(bus.out_z), 128'(pz));
        chk("hold_side", 128'(bus.out_side), 128'(ps));
        chk("hold_err", 128'(bus.out_err), 128'(pe));
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) chk("extra_out", 128'(bus.out_vld), 128'(0));
        else begin
          me = exp_q.pop_front();
          chk("z", 128'(bus.out_z), 128'(me.z));
          chk("side", 128'(bus.out_side), 128'(me.side));
          chk("err", 128'(bus.out_err), 128'(me.err));
        end
      end
      stall_p = bus.out_vld && !bus.out_rdy;
      pz = bus.out_z;
      ps = bus.out_side;
      pe = bus.out_err;
    end
  end
  task automatic step(input logic vld, input logic [63:0] a, input logic [63:0] b, input logic [7:0] s,
                      input exp_t e, output logic acc);
    bus.in_vld  = vld;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_side = s;
    @(negedge clk);
    acc = vld && bus.in_rdy;
    if (acc) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    if (rnd) bus.out_rdy = 1'($urandom_range(0, 1));
  endtask
  task automatic idle();
    logic acc;
    step(1'b0, '0, '0, '0, '0, acc);
  endtask
  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [7:0] s, input exp_t e, input bit rv);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 200) begin
      step(rv ? 1'($urandom_range(0, 1)) : 1'b1, a, b, s, e, acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 128'(acc), 128'(1));
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      idle();
      n++;
    end
    chk("drain_left", 128'(exp_q.size()), 128'(0));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    vec_t        vt[10];
    exp_t        e;
    logic [63:0] a, b;
    int          cyc, i, nv;
    logic        acc;
    bus.in_vld  = 1'b0;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.in_side = '0;
    bus.out_rdy = 1'b1;
    #2;
    chk("rst_out_vld", 128'(bus.out_vld), 128'(0));
    chk("rst_out_z", 128'(bus.out_z), 128'(0));
    chk("rst_out_side", 128'(bus.out_side), 128'(0));
    chk("rst_out_err", 128'(bus.out_err), 128'(0));
    chk("rst_in_rdy", 128'(bus.in_rdy), 128'(1));
    @(posedge clk);
    #1 a_rst_n = 1'b1;
    // latency: accept edge to out_vld
    push(64'd2, 64'd3, 8'h5A, '{z: 64'd6, side: 8'h5A, err: 1'b0}, 1'b0);
    cyc = 0;
    while (!bus.out_vld && cyc < 20) begin
      idle();
      cyc++;
    end
    chk("latency", 128'(cyc), 128'(5));
    drain();
    // boundaries, hand-computed, streamed back-to-back
    vt = '{
      '{64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000, 64'd1, 1'b0},
      '{64'h0000000100000000, 64'h0000000100000000, 64'h00000000FFFFFFFF, 1'b0},
      '{64'd0, 64'hFFFFFFFF00000000, 64'd0, 1'b0},
      '{64'hFFFFFFFF00000000, 64'd0, 64'd0, 1'b0},
      '{64'hFFFFFFFFFFFFFFFF, 64'd1, 64'h00000000FFFFFFFE, 1'b1},
      '{64'h0001000000000000, 64'h0001000000000000, 64'hFFFFFFFF00000000, 1'b0},
      '{64'hFFFFFFFF00000001, 64'd1, 64'd0, 1'b1},
      '{64'hFFFFFFFF00000000, 64'd1, 64'hFFFFFFFF00000000, 1'b0},
      '{64'h8000000000000000, 64'd2, 64'h00000000FFFFFFFF, 1'b0},
      '{64'd7, 64'd9, 64'd63, 1'b0}
    };
    for (int k = 0; k < 10; k++)
      push(vt[k].a, vt[k].b, 8'(k + 16), '{z: vt[k].z, side: 8'(k + 16), err: RC & vt[k].e}, 1'b0);
    drain();
    // backpressure: fill the pipe, stall 8 sampled cycles, then release
    i = 0;
    nv = 0;
    for (int c = 0; c <= 24; c++) begin
      bus.out_rdy = (c >= 14);
      if (bus.out_vld && !bus.out_rdy) chk("stall_in_rdy", 128'(bus.in_rdy), 128'(0));
      if (c >= 14 && c <= 23 && bus.out_vld) nv++;
      if (c == 24) chk("after_burst_vld", 128'(bus.out_vld), 128'(0));
      a = 64'(i) * 64'h0123456789ABCDEF;
      b = 64'hFFFFFFFF00000000 - 64'(i);
      step(i < 10, a, b, 8'(i + 8'h80), model(a, b, 8'(i + 8'h80)), acc);
      if (acc) i++;
    end
    chk("burst_consecutive", 128'(nv), 128'(10));
    drain();
    // random operands and handshakes on both sides
    rnd = 1'b1;
    for (int k = 0; k < 300; k++) begin
      a = {$urandom, $urandom};
      b = (k % 8 == 0) ? 64'hFFFFFFFFFFFFFFFF - 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      push(a, b, 8'(k), model(a, b, 8'(k)), 1'b1);
    end
    rnd = 1'b0;
    bus.out_rdy = 1'b1;
    drain();
    // reset with 3 items in flight
    for (int k = 0; k < 3; k++) push(64'(k + 1), 64'd5, 8'(k), '{z: 64'(5 * (k + 1)), side: 8'(k), err: 1'b0}, 1'b0);
    for (int k = 0; k < 3; k++) idle();
    chk("pre_rst_vld", 128'(bus.out_vld), 128'(1));
    exp_q.delete();
    a_rst_n = 1'b0;
    #1;
    chk("rst_async_vld", 128'(bus.out_vld), 128'(0));
    @(posedge clk);
    #1 a_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) idle();
    chk("post_rst_idle", 128'(bus.out_vld), 128'(0));
    push(64'd7, 64'd9, 8'h3C, '{z: 64'd63, side: 8'h3C, err: 1'b0}, 1'b0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
